// File: rtl/sram_pkg.sv
// Shared constants and FSM state encoding for the SRAM block reader.
package sram_pkg;

  localparam int DATA_WIDTH    = 2048;
  localparam int ADDR_WIDTH    = 12;
  localparam int BLK_COUNT     = 3600;
  localparam int BYTES_PER_BLK = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_STREAM  = 2'd3
  } state_e;

endpackage

// File: rtl/blk_serializer.sv
// Holds one captured SRAM word and emits it as a valid/ready byte stream, byte 0 first,
// flagging the final byte with out_last_o.
module blk_serializer
  import sram_pkg::*;
#(
  parameter int BUF_WIDTH = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [BUF_WIDTH-1:0] load_data_i,
  input  logic                 out_ready_i,
  output logic                 out_valid_o,
  output logic [7:0]           out_data_o,
  output logic                 out_last_o,
  output logic                 done_o
);

  localparam logic [7:0] PreLastIdx = 8'(BYTES_PER_BLK - 2);

  logic [BUF_WIDTH-1:0] buf_q, buf_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 fire_s;

  // Next-state for the byte buffer: the current byte always sits in the low 8 bits.
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    fire_s  = valid_q && out_ready_i;
    if (load_i) begin
      buf_d   = load_data_i;
      cnt_d   = 8'd0;
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (fire_s && last_q) begin
      buf_d   = '0;
      cnt_d   = cnt_q + 8'd1;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (fire_s) begin
      buf_d   = buf_q >> 8;
      cnt_d   = cnt_q + 8'd1;
      valid_d = 1'b1;
      last_d  = (cnt_q == PreLastIdx);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Buffer, counter and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      cnt_q   <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = buf_q[7:0];
  assign out_last_o  = last_q;
  assign done_o      = fire_s && last_q;

endmodule

// File: rtl/sram_block_reader.sv
// Reads one DATA_WIDTH-bit block from a 1-cycle-latency SRAM and streams it as 256 bytes.
// Define SRAM_READER_RANGE_CHK_EN to reject addresses >= BLK_COUNT with a one-cycle err pulse.
module sram_block_reader #(
  parameter int DATA_WIDTH = sram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_pkg::ADDR_WIDTH,
  parameter int BLK_COUNT  = sram_pkg::BLK_COUNT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  sram_csb,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic                  err
);
  import sram_pkg::*;

`ifdef SRAM_READER_RANGE_CHK_EN
  localparam bit RangeChkEn = 1'b1;
`else
  localparam bit RangeChkEn = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  csb_q, csb_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  accept_s;
  logic                  addr_oob_s;
  logic                  load_s;
  logic                  done_s;

  // FSM next-state; csb and req_ready are derived from the next state so they come out registered.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    err_d      = 1'b0;
    load_s     = 1'b0;
    accept_s   = req_valid && ready_q;
    addr_oob_s = RangeChkEn && (32'(req_addr) >= 32'(BLK_COUNT));
    case (state_q)
      ST_IDLE: begin
        if (accept_s && addr_oob_s) begin
          err_d = 1'b1;
        end else if (accept_s) begin
          state_d = ST_ISSUE;
          addr_d  = req_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        load_s  = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    csb_d   = (state_d != ST_ISSUE);
    ready_d = (state_d == ST_IDLE);
  end

  // Control registers; reset aborts any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      csb_q   <= 1'b1;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      csb_q   <= csb_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  blk_serializer #(
    .BUF_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_s),
    .load_data_i (sram_dout),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .done_o      (done_s)
  );

  assign req_ready = ready_q;
  assign sram_csb  = csb_q;
  assign sram_addr = addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sram_block_reader.sv
// Directed self-checking bench for sram_block_reader with a 1-cycle-latency SRAM model.
`timescale 1ns/1ps
module tb_sram_block_reader;

  localparam int DW = 2048;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          sram_csb;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout;
  logic          out_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_last;
  logic          err;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [7:0]    rx_data[256];
  logic          rx_last[256];
  logic [AW-1:0] csb_log[$];

  always #5 clk = ~clk;

  sram_block_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLK_COUNT(3600)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .sram_csb(sram_csb), .sram_addr(sram_addr), .sram_dout(sram_dout), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .err(err)
  );

  // Memory contents: block a, byte k = k + (a-5)*37 mod 256, so block 5 holds 0x00..0xFF.
  function automatic logic [7:0] exp_byte(input int a, input int k);
    int v;
    v = (k + (a - 5) * 37) & 255;
    return v[7:0];
  endfunction

  function automatic logic [DW-1:0] mk_word(input int a);
    logic [DW-1:0] w;
    for (int k = 0; k < 256; k++) w[8*k +: 8] = exp_byte(a, k);
    return w;
  endfunction

  always @(posedge clk) begin
    if (sram_csb === 1'b0) begin
      sram_dout <= mk_word(int'(sram_addr));
      csb_log.push_back(sram_addr);
    end
  end

  // Presents a request at a negedge and waits (bounded) for the accepting edge; returns at the ISSUE negedge.
  task automatic issue_req(input logic [AW-1:0] a, input bit keep, output bit ok);
    int cyc;
    cyc = 0;
    ok = 1'b0;
    req_addr = a;
    req_valid = 1'b1;
    while (!ok && cyc < 50) begin
      if (req_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    req_valid = keep;
  endtask

  // Collects handshaken bytes into rx_data/rx_last; returns at the negedge after the last handshake.
  task automatic receive_block(input bit stall, input int max_bytes, output int n,
                               output int stall_err, output int stalls, output logic ready_at_last);
    logic [7:0] held_d;
    logic       held_l;
    bit         was_stall;
    int         cyc;
    n = 0; stall_err = 0; stalls = 0; was_stall = 1'b0; ready_at_last = 1'b0; cyc = 0;
    held_d = 8'h00; held_l = 1'b0;
    while (n < max_bytes && cyc < 3000) begin
      out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (was_stall && (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l)) stall_err++;
      was_stall = 1'b0;
      if (out_valid === 1'b1 && out_ready) begin
        rx_data[n] = out_data;
        rx_last[n] = out_last;
        if (out_last === 1'b1) ready_at_last = req_ready;
        n++;
      end else if (out_valid === 1'b1) begin
        was_stall = 1'b1;
        held_d = out_data;
        held_l = out_last;
        stalls++;
      end else begin
        was_stall = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (n > 0 && rx_last[n-1] === 1'b1) break;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    if (sram_csb !== 1'b1) $display("FAIL rst_csb: got %b want 1", sram_csb); else n_pass++;
    n_checks++;
    if (sram_addr !== 12'd0) $display("FAIL rst_addr: got %0d want 0", sram_addr); else n_pass++;
    n_checks++;
    if ({out_valid, out_data, out_last} !== 10'd0) $display("FAIL rst_out: got %h want 0", {out_valid, out_data, out_last}); else n_pass++;
    n_checks++;
    if ({err, req_ready} !== 2'b00) $display("FAIL rst_err_ready: got %b want 00", {err, req_ready}); else n_pass++;
    n_checks++;
    rst = 1'b0;
    @(negedge clk);
    if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++;
  endtask

  task automatic test_basic();
    bit ok; int n, se, st, errs; logic ral;
    csb_log.delete();
    issue_req(12'd5, 1'b0, ok);
    if (!ok) $display("FAIL basic_accept: timeout waiting for req_ready"); else n_pass++;
    n_checks++;
    if (sram_csb !== 1'b0 || sram_addr !== 12'd5 || out_valid !== 1'b0)
      $display("FAIL basic_issue: csb=%b addr=%0d valid=%b want 0/5/0", sram_csb, sram_addr, out_valid);
    else n_pass++;
    n_checks++;
    @(negedge clk);
    if (sram_csb !== 1'b1 || out_valid !== 1'b0) $display("FAIL basic_capture: csb=%b valid=%b want 1/0", sram_csb, out_valid); else n_pass++;
    n_checks++;
    @(negedge clk);
    if (out_valid !== 1'b1 || out_data !== 8'h00) $display("FAIL basic_first_valid: valid=%b data=%h want 1/00", out_valid, out_data); else n_pass++;
    n_checks++;
    receive_block(1'b0, 256, n, se, st, ral);
    if (n != 256) $display("FAIL basic_count: got %0d bytes want 256", n); else n_pass++;
    n_checks++;
    errs = 0;
    for (int k = 0; k < 256; k++) begin
      logic [31:0] kk;
      kk = k;
      if (rx_data[k] !== kk[7:0] || rx_last[k] !== (k == 255)) errs++;
    end
    if (errs != 0) $display("FAIL basic_data: %0d bad bytes want 0", errs); else n_pass++;
    n_checks++;
    if (csb_log.size() != 1) $display("FAIL basic_csb_once: got %0d accesses want 1", csb_log.size()); else n_pass++;
    n_checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL basic_idle_after: ready=%b valid=%b want 1/0", req_ready, out_valid); else n_pass++;
    n_checks++;
  endtask

  task automatic test_stall();
    bit ok; int n, se, st, errs; logic ral;
    issue_req(12'd5, 1'b0, ok);
    repeat (2) @(negedge clk);
    receive_block(1'b1, 256, n, se, st, ral);
    if (n != 256) $display("FAIL stall_count: got %0d bytes want 256", n); else n_pass++;
    n_checks++;
    errs = 0;
    for (int k = 0; k < 256; k++) if (rx_data[k] !== exp_byte(5, k) || rx_last[k] !== (k == 255)) errs++;
    if (errs != 0) $display("FAIL stall_data: %0d bad bytes want 0", errs); else n_pass++;
    n_checks++;
    if (se != 0) $display("FAIL stall_hold: %0d unstable stall cycles want 0", se); else n_pass++;
    n_checks++;
    if (st == 0) $display("FAIL stall_seen: got %0d stall cycles want >0", st); else n_pass++;
    n_checks++;
  endtask

  task automatic test_ignore();
    bit ok; int n, se, st, errs; logic ral;
    csb_log.delete();
    issue_req(12'd5, 1'b0, ok);
    req_addr = 12'd7;
    req_valid = 1'b1;
    repeat (2) @(negedge clk);
    receive_block(1'b0, 256, n, se, st, ral);
    if (csb_log.size() != 1 || ral !== 1'b0) $display("FAIL ignore_during_stream: accesses=%0d ready=%b want 1/0", csb_log.size(), ral); else n_pass++;
    n_checks++;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (sram_csb !== 1'b0 || sram_addr !== 12'd7) $display("FAIL ignore_issue7: csb=%b addr=%0d want 0/7", sram_csb, sram_addr); else n_pass++;
    n_checks++;
    repeat (2) @(negedge clk);
    receive_block(1'b0, 256, n, se, st, ral);
    errs = 0;
    for (int k = 0; k < 256; k++) if (rx_data[k] !== exp_byte(7, k) || rx_last[k] !== (k == 255)) errs++;
    if (n != 256 || errs != 0) $display("FAIL ignore_data7: n=%0d bad=%0d want 256/0", n, errs); else n_pass++;
    n_checks++;
    if (csb_log.size() != 2) $display("FAIL ignore_once: got %0d accesses want 2", csb_log.size()); else n_pass++;
    n_checks++;
  endtask

  task automatic test_reset_mid();
    bit ok; int n, se, st, errs, seen; logic ral;
    issue_req(12'd5, 1'b0, ok);
    repeat (2) @(negedge clk);
    receive_block(1'b0, 100, n, se, st, ral);
    if (n != 100 || out_data !== 8'd100) $display("FAIL rstmid_pre: n=%0d data=%h want 100/64", n, out_data); else n_pass++;
    n_checks++;
    #1 rst = 1'b1;
    #1;
    if ({out_valid, out_data, out_last, sram_csb, sram_addr, req_ready, err} !== {1'b0, 8'h00, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0})
      $display("FAIL rstmid_outputs: got %h want %h", {out_valid, out_data, out_last, sram_csb, sram_addr, req_ready, err},
               {1'b0, 8'h00, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0});
    else n_pass++;
    n_checks++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    if (seen != 0) $display("FAIL rstmid_no_resume: got %0d valid cycles want 0", seen); else n_pass++;
    n_checks++;
    csb_log.delete();
    issue_req(12'd3599, 1'b0, ok);
    repeat (2) @(negedge clk);
    receive_block(1'b0, 256, n, se, st, ral);
    errs = 0;
    for (int k = 0; k < 256; k++) if (rx_data[k] !== exp_byte(3599, k) || rx_last[k] !== (k == 255)) errs++;
    if (n != 256 || errs != 0) $display("FAIL rstmid_block3599: n=%0d bad=%0d want 256/0", n, errs); else n_pass++;
    n_checks++;
    if (csb_log.size() != 1 || csb_log[0] !== 12'd3599) $display("FAIL rstmid_addr: accesses=%0d want 1 at 3599", csb_log.size()); else n_pass++;
    n_checks++;
  endtask

  task automatic test_range();
    bit ok; int n, se, st, seen; logic ral;
    csb_log.delete();
    issue_req(12'd3600, 1'b0, ok);
`ifdef SRAM_READER_RANGE_CHK_EN
    if (err !== 1'b1 || sram_csb !== 1'b1) $display("FAIL range_err: err=%b csb=%b want 1/1", err, sram_csb); else n_pass++;
    n_checks++;
    @(negedge clk);
    if (err !== 1'b0 || req_ready !== 1'b1) $display("FAIL range_pulse: err=%b ready=%b want 0/1", err, req_ready); else n_pass++;
    n_checks++;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    if (seen != 0 || csb_log.size() != 0) $display("FAIL range_no_access: valid=%0d accesses=%0d want 0/0", seen, csb_log.size()); else n_pass++;
    n_checks++;
`else
    if (sram_csb !== 1'b0 || sram_addr !== 12'd3600 || err !== 1'b0)
      $display("FAIL range_issue: csb=%b addr=%0d err=%b want 0/3600/0", sram_csb, sram_addr, err);
    else n_pass++;
    n_checks++;
    repeat (2) @(negedge clk);
    receive_block(1'b0, 256, n, se, st, ral);
    if (n != 256 || rx_data[0] !== exp_byte(3600, 0)) $display("FAIL range_stream: n=%0d b0=%h want 256/%h", n, rx_data[0], exp_byte(3600, 0)); else n_pass++;
    n_checks++;
`endif
  endtask

  task automatic test_back_to_back();
    bit ok; int n, se, st, errs; logic ral;
    csb_log.delete();
    issue_req(12'd0, 1'b0, ok);
    repeat (2) @(negedge clk);
    receive_block(1'b0, 256, n, se, st, ral);
    errs = 0;
    for (int k = 0; k < 256; k++) if (rx_data[k] !== exp_byte(0, k) || rx_last[k] !== (k == 255)) errs++;
    if (n != 256 || errs != 0) $display("FAIL b2b_block0: n=%0d bad=%0d want 256/0", n, errs); else n_pass++;
    n_checks++;
    if (ral !== 1'b0 || req_ready !== 1'b1) $display("FAIL b2b_ready_timing: at_last=%b after=%b want 0/1", ral, req_ready); else n_pass++;
    n_checks++;
    issue_req(12'd1, 1'b0, ok);
    repeat (2) @(negedge clk);
    receive_block(1'b0, 256, n, se, st, ral);
    errs = 0;
    for (int k = 0; k < 256; k++) if (rx_data[k] !== exp_byte(1, k) || rx_last[k] !== (k == 255)) errs++;
    if (n != 256 || errs != 0) $display("FAIL b2b_block1: n=%0d bad=%0d want 256/0", n, errs); else n_pass++;
    n_checks++;
    if (csb_log.size() != 2 || csb_log[0] !== 12'd0 || csb_log[1] !== 12'd1)
      $display("FAIL b2b_addrs: accesses=%0d want 2 (0 then 1)", csb_log.size());
    else n_pass++;
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_ignore();
    test_reset_mid();
    test_range();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
